// File: rtl/frame_blit_sequencer.sv
// Frame-copy sequencer: on each timer tick, copies one frame from the source RAM into VRAM and then requests a draw.
// Keyboard codes select the frame and toggle auto-advance.
module frame_blit_sequencer #(
   parameter int DATA_W           = 16,
   parameter int FRAME_ADDR_BITS  = 10,
   parameter int FRAME_COUNT_BITS = 2,
   parameter int VRAM_ADDR_W      = 16,
   parameter bit AUTO_DEFAULT     = 1'b0
) (
   input  logic                                   CLK,
   input  logic                                   IN_PB_RESET,
   output logic                                   RAM_EN,
   output logic [FRAME_COUNT_BITS+FRAME_ADDR_BITS-1:0] RAM_ADDR,
   input  logic [DATA_W-1:0]                      RAM_DATA,
   output logic                                   VRAM_EN,
   output logic                                   VRAM_WE,
   output logic [VRAM_ADDR_W-1:0]                 VRAM_ADDR,
   output logic [DATA_W-1:0]                      VRAM_DATA_W,
   input  logic                                   GPU_READY,
   output logic                                   GPU_DRAW,
   input  logic                                   ST_IRQ,
   output logic                                   ST_IACK,
   output logic                                   ST_IEND,
   input  logic                                   K_IRQ,
   input  logic [7:0]                             K_DATA,
   output logic                                   K_IACK,
   output logic                                   K_IEND,
   output logic [FRAME_COUNT_BITS-1:0]            FRAME_SEL,
   output logic                                   AUTO_MODE,
   output logic [7:0]                             SKIP_COUNT
);

   // state | meaning
   // IDLE  | wait for timer IRQ (priority) or keyboard IRQ
   // TACK  | acknowledge timer, decide copy or skip
   // COPY  | one RAM read per cycle, VRAM write lags by one
   // DRAIN | write the last word
   // DRAW  | draw request, timer end, optional frame advance
   // TSKIP | GPU busy: end timer IRQ and count the skip
   // KACK  | acknowledge keyboard
   // KLOAD | latch the key code
   // KEND  | end keyboard IRQ and apply the command
   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_TACK  = 4'd1,
      S_COPY  = 4'd2,
      S_DRAIN = 4'd3,
      S_DRAW  = 4'd4,
      S_TSKIP = 4'd5,
      S_KACK  = 4'd6,
      S_KLOAD = 4'd7,
      S_KEND  = 4'd8
   } state_t;

   localparam int unsigned FRAMES = 1 << FRAME_COUNT_BITS;

   state_t                      state, state_nx;
   logic [FRAME_ADDR_BITS-1:0]  word;
   logic [FRAME_ADDR_BITS-1:0]  word_prev;
   logic [7:0]                  key;
   logic [7:0]                  key_n;
   logic                        key_is_sel;
   logic                        last_word;

   assign last_word  = (word == {FRAME_ADDR_BITS{1'b1}});
   assign word_prev  = word - FRAME_ADDR_BITS'(1);
   assign key_n      = key - 8'h31;
   assign key_is_sel = (key >= 8'h31) && (key_n <= 8'd8) && (32'(key_n) < FRAMES);

   always_ff @(posedge CLK or negedge IN_PB_RESET) begin
      if (!IN_PB_RESET) state <= S_IDLE;
      else              state <= state_nx;
   end

   always_comb begin
      state_nx = S_IDLE;
      case (state)
         S_IDLE: begin
            if (ST_IRQ)     state_nx = S_TACK;
            else if (K_IRQ) state_nx = S_KACK;
            else            state_nx = S_IDLE;
         end
         S_TACK:  state_nx = GPU_READY ? S_COPY : S_TSKIP;
         S_COPY:  state_nx = last_word ? S_DRAIN : S_COPY;
         S_DRAIN: state_nx = S_DRAW;
         S_DRAW:  state_nx = S_IDLE;
         S_TSKIP: state_nx = S_IDLE;
         S_KACK:  state_nx = S_KLOAD;
         S_KLOAD: state_nx = S_KEND;
         S_KEND:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      RAM_EN   = 1'b0;
      VRAM_EN  = 1'b0;
      VRAM_WE  = 1'b0;
      GPU_DRAW = 1'b0;
      ST_IACK  = 1'b0;
      ST_IEND  = 1'b0;
      K_IACK   = 1'b0;
      K_IEND   = 1'b0;
      case (state)
         S_TACK:  ST_IACK = 1'b1;
         S_COPY: begin
            RAM_EN  = 1'b1;
            // the first copy cycle only issues a read; nothing has arrived yet to write
            VRAM_EN = (word != '0);
            VRAM_WE = (word != '0);
         end
         S_DRAIN: begin
            VRAM_EN = 1'b1;
            VRAM_WE = 1'b1;
         end
         S_DRAW: begin
            ST_IEND  = 1'b1;
            GPU_DRAW = 1'b1;
         end
         S_TSKIP: ST_IEND = 1'b1;
         S_KACK:  K_IACK  = 1'b1;
         S_KEND:  K_IEND  = 1'b1;
         default: ;
      endcase
   end

   assign RAM_ADDR    = {FRAME_SEL, word};
   // word has already wrapped to 0 in DRAIN, so word-1 names the last word
   assign VRAM_ADDR   = VRAM_ADDR_W'(word_prev);
   assign VRAM_DATA_W = RAM_DATA;

   always_ff @(posedge CLK or negedge IN_PB_RESET) begin
      if (!IN_PB_RESET) begin
         word       <= '0;
         key        <= '0;
         FRAME_SEL  <= '0;
         AUTO_MODE  <= AUTO_DEFAULT;
         SKIP_COUNT <= '0;
      end else begin
         case (state)
            S_TACK:  word <= '0;
            S_COPY:  word <= word + FRAME_ADDR_BITS'(1);
            S_TSKIP: if (SKIP_COUNT != 8'hFF) SKIP_COUNT <= SKIP_COUNT + 8'd1;
            S_DRAW:  if (AUTO_MODE) FRAME_SEL <= FRAME_SEL + FRAME_COUNT_BITS'(1);
            S_KLOAD: key <= K_DATA;
            S_KEND: begin
               if (key_is_sel)          FRAME_SEL <= FRAME_COUNT_BITS'(key_n);
               else if (key == 8'h20)   AUTO_MODE <= ~AUTO_MODE;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/frame_blit_sequencer.md
Name: frame_blit_sequencer

Overview:
- Parametrised frame-copy sequencer: on each system-timer tick it block-copies one frame of words from a multi-frame source RAM into VRAM through the GFXController port, then pulses a draw request.
- Keyboard codes select the frame and toggle an auto-advance animation mode.
- It is the pipelined, generalised successor to the fixed 4-frame, 1 Kword test-suite sequencer, and sits between SystemTimer, KBDController, the frame RAM and GFXController.

Parameters:
DATA_W, 16, width of the RAM and VRAM data words
FRAME_ADDR_BITS, 10, word address bits per frame; N = 2^FRAME_ADDR_BITS words per frame
FRAME_COUNT_BITS, 2, frame index bits; F = 2^FRAME_COUNT_BITS frames
VRAM_ADDR_W, 16, VRAM address width; must be >= FRAME_ADDR_BITS, upper bits driven 0
AUTO_DEFAULT, 0, value loaded into AUTO_MODE at reset

Ports:
CLK  in  1  system clock, all logic on rising edge
IN_PB_RESET  in  1  asynchronous active-low reset
RAM_EN  out  1  source RAM read enable; data is valid on RAM_DATA the following cycle
RAM_ADDR  out  FRAME_COUNT_BITS+FRAME_ADDR_BITS  {frame index, word index}
RAM_DATA  in  DATA_W  source RAM read data
VRAM_EN  out  1  VRAM access enable
VRAM_WE  out  1  VRAM write strobe
VRAM_ADDR  out  VRAM_ADDR_W  VRAM word address
VRAM_DATA_W  out  DATA_W  VRAM write data
GPU_READY  in  1  GFXController idle
GPU_DRAW  out  1  one-cycle draw request
ST_IRQ  in  1  system timer interrupt request
ST_IACK  out  1  timer interrupt acknowledge pulse
ST_IEND  out  1  timer interrupt end pulse
K_IRQ  in  1  keyboard interrupt request
K_DATA  in  8  keyboard code, valid after K_IACK
K_IACK  out  1  keyboard interrupt acknowledge pulse
K_IEND  out  1  keyboard interrupt end pulse
FRAME_SEL  out  FRAME_COUNT_BITS  current frame index
AUTO_MODE  out  1  auto-advance enabled
SKIP_COUNT  out  8  ticks dropped because GPU was busy; saturates at 255

Behaviour:
- Reset (IN_PB_RESET=0, takes effect asynchronously):
  - state IDLE.
  - Every strobe/pulse output is 0: RAM_EN, VRAM_EN, VRAM_WE, GPU_DRAW, and all IACK/IEND outputs.
  - FRAME_SEL=0, AUTO_MODE=AUTO_DEFAULT, SKIP_COUNT=0, word counter=0, key latch=0.
  - Reset mid-copy aborts the copy immediately; no further VRAM writes occur.
- States: IDLE, TACK, COPY, DRAIN, DRAW, TSKIP, KACK, KLOAD, KEND.
- IDLE:
  - ST_IRQ=1 -> TACK; else K_IRQ=1 -> KACK. The timer has priority when both are asserted.
  - IRQs are only sampled in IDLE. A keyboard IRQ arriving during a copy stays pending and is serviced afterwards.
- TACK: ST_IACK=1 for one cycle. GPU_READY=1 -> COPY with word counter w=0; else -> TSKIP.
- TSKIP: ST_IEND=1 and SKIP_COUNT+1 (saturating) -> IDLE.
- COPY:
  - Each cycle: RAM_EN=1, RAM_ADDR={FRAME_SEL, w}, w+1.
  - From the second COPY cycle on: VRAM_EN=VRAM_WE=1, VRAM_ADDR=w-1 zero-extended, VRAM_DATA_W=RAM_DATA.
  - Throughput is one word per cycle.
  - The cycle issuing w=N-1 -> DRAIN. The counter wraps to 0 and does not spill into the frame bits.
- DRAIN: writes word N-1 -> DRAW.
- DRAW:
  - ST_IEND=1, GPU_DRAW=1 for one cycle.
  - If AUTO_MODE: FRAME_SEL+1, wrapping F-1 -> 0.
  - -> IDLE.
- FRAME_SEL is constant for the duration of a copy.
- Latency: IACK cycle t; reads t+1..t+N; writes t+2..t+N+1; GPU_DRAW and ST_IEND at t+N+2.
- KACK: K_IACK=1 for one cycle -> KLOAD.
- KLOAD: latches K_DATA -> KEND.
- KEND: K_IEND=1 and the command is applied -> IDLE.
  - Code 0x31+n with n < F and n <= 8: FRAME_SEL=n.
  - Code 0x20: toggle AUTO_MODE.
  - Any other code: ignored.
- Unused state encodings -> IDLE.

Test Plan:
- Reset, FRAME_SEL=0, GPU_READY=1, ST_IRQ pulse -> ST_IACK at t; VRAM receives exactly N=1024 writes, addresses 0..1023, data = RAM[0..1023]; GPU_DRAW and ST_IEND high at t+1026; FRAME_SEL stays 0.
- Key 0x33 then a tick -> K_IACK, then K_IEND; FRAME_SEL=2; first RAM_ADDR=0x800, last RAM_ADDR=0xBFF.
- Key 0x35 with F=4 -> ignored, FRAME_SEL unchanged. Key 0x20 -> AUTO_MODE=1; four ticks copy frames 2,3,0,1 (wrap checked).
- GPU_READY=0 on tick -> ST_IACK then ST_IEND, no RAM_EN/VRAM_WE activity, SKIP_COUNT=1; 300 such ticks -> SKIP_COUNT=255.
- ST_IRQ and K_IRQ asserted in the same cycle -> timer serviced first; key serviced after DRAW; the key is not applied to the copy in progress.
- IN_PB_RESET asserted at word 500 of a copy -> VRAM_WE drops asynchronously, all outputs at reset values; the next tick restarts from word 0. Repeat with DATA_W=8, FRAME_ADDR_BITS=6, FRAME_COUNT_BITS=3 -> 64-word copies, 8 frames.
